// File: rtl/data_mem_responder_if.sv
// Processor data-port bundle: address, store data and strobes out; load data, stall and error back.
// No storage; pure wiring between the processor and the data-memory responder.
// The processor holds its strobes until pc_enable returns high.
interface data_mem_responder_if;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic        ctrl_mem_read;
  logic        ctrl_mem_write;
  logic [31:0] data_out;
  logic        pc_enable;
  logic        mem_err;

  // Processor side drives the request, memory side answers it
  modport master (
    output data_addr, data_in, ctrl_mem_read, ctrl_mem_write,
    input  data_out, pc_enable, mem_err
  );

  modport slave (
    input  data_addr, data_in, ctrl_mem_read, ctrl_mem_write,
    output data_out, pc_enable, mem_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word data memory for a single-cycle core; stalls the core until each load/store completes.
// Latency: pc_enable low for LATENCY cycles per access, then one DONE cycle with results valid.
// Backpressure: pc_enable low stalls the core; strobes are latched at accept so later changes are ignored.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  // Counter preload so BUSY lasts LATENCY-1 cycles; unused when LATENCY is 1
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   data_out_q, data_out_d;
  logic          mem_err_q, mem_err_d;

  logic [31:0]   mem [DEPTH];

  logic          req;
  logic          commit;
  logic          c_rd, c_wr;
  logic [31:0]   c_addr, c_wdata;
  logic [AW-1:0] idx;
  logic          err;
  logic          mem_we;
  logic          pc_en;

  assign req = bus.ctrl_mem_read | bus.ctrl_mem_write;

  // Next-state, request latching and commit of the completing access
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    mem_err_d  = mem_err_q;
    commit     = 1'b0;
    pc_en      = 1'b1;
    // Commit normally works from the latched copy
    c_rd       = rd_q;
    c_wr       = wr_q;
    c_addr     = addr_q;
    c_wdata    = wdata_q;

    case (state_q)
      IDLE: begin
        pc_en = ~req;
        if (req) begin
          rd_d    = bus.ctrl_mem_read;
          wr_d    = bus.ctrl_mem_write;
          addr_d  = bus.data_addr;
          wdata_d = bus.data_in;
          if (LATENCY == 1) begin
            // Accept edge is also the commit edge, so the latch is not yet loaded
            state_d = DONE;
            commit  = 1'b1;
            c_rd    = bus.ctrl_mem_read;
            c_wr    = bus.ctrl_mem_write;
            c_addr  = bus.data_addr;
            c_wdata = bus.data_in;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        pc_en = 1'b0;
        if (cnt_q == '0) begin
          state_d = DONE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        // Held strobes belong to the finished instruction; never re-accept here
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    idx = c_addr[AW+1:2];
    // DEPTH is a power of two, so out-of-range means any word-address bit above the index is set
    err = (c_addr[1:0] != 2'b00) || (c_addr[31:AW+2] != '0) || (c_rd && c_wr);

    if (commit) begin
      mem_err_d = err;
      if (c_rd) begin
        data_out_d = err ? 32'h0 : mem[idx];
      end
    end

    // A reset arriving on a commit edge must not leave a partial store behind
    mem_we = commit && c_wr && !err && rst_n;
  end

  // Control and output registers; async reset aborts any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= c_wdata;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.mem_err   = mem_err_q;
  // Core must be free to run while reset is asserted
  assign bus.pc_enable = pc_en | ~rst_n;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances at LATENCY 1, 2 and 4 against a transaction-level model.
// Each access is driven like the core would: strobes held until the DONE cycle, dropped after it.
// Expected stall length, load data and error flag come from the model's memory array and address rules.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int lat [3] = '{1, 2, 4};

  logic [31:0] a_addr  [3];
  logic [31:0] a_wdata [3];
  logic        a_rd    [3];
  logic        a_wr    [3];
  logic        a_rstn  [3];
  logic [31:0] o_dout  [3];
  logic        o_pce   [3];
  logic        o_err   [3];

  data_mem_responder_if if0 ();
  data_mem_responder_if if1 ();
  data_mem_responder_if if2 ();

  assign if0.data_addr = a_addr[0];  assign if0.data_in = a_wdata[0];
  assign if0.ctrl_mem_read = a_rd[0]; assign if0.ctrl_mem_write = a_wr[0];
  assign if1.data_addr = a_addr[1];  assign if1.data_in = a_wdata[1];
  assign if1.ctrl_mem_read = a_rd[1]; assign if1.ctrl_mem_write = a_wr[1];
  assign if2.data_addr = a_addr[2];  assign if2.data_in = a_wdata[2];
  assign if2.ctrl_mem_read = a_rd[2]; assign if2.ctrl_mem_write = a_wr[2];

  assign o_dout[0] = if0.data_out; assign o_pce[0] = if0.pc_enable; assign o_err[0] = if0.mem_err;
  assign o_dout[1] = if1.data_out; assign o_pce[1] = if1.pc_enable; assign o_err[1] = if1.mem_err;
  assign o_dout[2] = if2.data_out; assign o_pce[2] = if2.pc_enable; assign o_err[2] = if2.mem_err;

  data_mem_responder #(.DEPTH(256), .LATENCY(1)) u_l1 (.clk(clk), .rst_n(a_rstn[0]), .bus(if0.slave));
  data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (.clk(clk), .rst_n(a_rstn[1]), .bus(if1.slave));
  data_mem_responder #(.DEPTH(256), .LATENCY(4)) u_l4 (.clk(clk), .rst_n(a_rstn[2]), .bus(if2.slave));

  // Reference state: memory contents and last committed outputs per instance
  logic [31:0] mm    [3][256];
  logic [31:0] exp_d [3];
  logic        exp_e [3];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One core access on instance k; called at a negedge with that instance idle
  task automatic access(input int k, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit scramble);
    logic       err;
    logic [7:0] idx;
    a_rd[k] = rd; a_wr[k] = wr; a_addr[k] = addr; a_wdata[k] = wdata;
    for (int i = 0; i < lat[k]; i++) begin
      #1;
      chk($sformatf("k%0d_stall%0d", k, i), {31'b0, o_pce[k]}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      if (scramble && i < lat[k] - 1) begin
        a_addr[k]  = $urandom;
        a_wdata[k] = $urandom;
      end
    end
    err = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd256) || (rd && wr);
    idx = addr[9:2];
    if (!err && wr) mm[k][idx] = wdata;
    if (rd) exp_d[k] = err ? 32'h0 : mm[k][idx];
    exp_e[k] = err;
    #1;
    chk($sformatf("k%0d_done_pce", k), {31'b0, o_pce[k]}, 32'd1);
    chk($sformatf("k%0d_dout a=%h", k, addr), o_dout[k], exp_d[k]);
    chk($sformatf("k%0d_err a=%h", k, addr), {31'b0, o_err[k]}, {31'b0, exp_e[k]});
    @(posedge clk);
    @(negedge clk);
    a_rd[k] = 1'b0; a_wr[k] = 1'b0;
  endtask

  // Non-memory cycles: no stall, outputs hold
  task automatic idle(input int k, input int n);
    a_rd[k] = 1'b0; a_wr[k] = 1'b0; a_addr[k] = $urandom;
    for (int i = 0; i < n; i++) begin
      #1;
      chk($sformatf("k%0d_idle_pce", k), {31'b0, o_pce[k]}, 32'd1);
      chk($sformatf("k%0d_idle_dout", k), o_dout[k], exp_d[k]);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    logic        rd, wr;
    int          k, sel;

    for (int j = 0; j < 3; j++) begin
      a_rstn[j] = 1'b0; a_rd[j] = 1'b0; a_wr[j] = 1'b0;
      a_addr[j] = '0; a_wdata[j] = '0;
      exp_d[j] = '0; exp_e[j] = 1'b0;
    end
    a_rd[0] = 1'b1;  // request while in reset must not stall
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_pce_req", {31'b0, o_pce[0]}, 32'd1);
    a_rd[0] = 1'b0;
    for (int j = 0; j < 3; j++) a_rstn[j] = 1'b1;
    @(negedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("k%0d_rst_dout", j), o_dout[j], 32'h0);
      chk($sformatf("k%0d_rst_err", j), {31'b0, o_err[j]}, 32'd0);
      chk($sformatf("k%0d_rst_pce", j), {31'b0, o_pce[j]}, 32'd1);
    end
    @(negedge clk);

    // Give words 0..15 known contents in every instance
    for (int j = 0; j < 3; j++)
      for (int w = 0; w < 16; w++)
        access(j, 1'b0, 1'b1, 32'(w * 4), $urandom, 1'b0);

    // Write then read back at LATENCY 2
    access(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("l2_readback", o_dout[1], 32'hDEADBEEF);

    // Back-to-back at LATENCY 1
    access(0, 1'b0, 1'b1, 32'h0, 32'h1, 1'b0);
    access(0, 1'b0, 1'b1, 32'h4, 32'h2, 1'b0);
    access(0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    chk("l1_b2b_read", o_dout[0], 32'h2);

    // Misaligned store leaves mem[4] alone; misaligned load returns 0
    access(1, 1'b0, 1'b1, 32'h13, 32'hCAFEF00D, 1'b0);
    chk("mis_wr_err", {31'b0, o_err[1]}, 32'd1);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("mis_wr_nochg", o_dout[1], 32'hDEADBEEF);
    access(1, 1'b1, 1'b0, 32'h12, 32'h0, 1'b0);
    chk("mis_rd_dout", o_dout[1], 32'h0);

    // Out of range, then a good read clears the flag
    access(1, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0);
    chk("oor_err", {31'b0, o_err[1]}, 32'd1);
    access(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("oor_clear", {31'b0, o_err[1]}, 32'd0);
    access(1, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0);  // last valid word

    // Dual strobe: no write, zero data
    access(1, 1'b0, 1'b1, 32'h8, 32'h12345678, 1'b0);
    access(1, 1'b1, 1'b1, 32'h8, 32'hFFFFFFFF, 1'b0);
    chk("dual_dout", o_dout[1], 32'h0);
    access(1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
    chk("dual_nowrite", o_dout[1], 32'h12345678);

    // Reset during the second BUSY cycle of a LATENCY-4 store
    access(2, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    access(2, 1'b0, 1'b1, 32'h21, 32'h0, 1'b0);  // sets error, keeps load data
    a_rd[2] = 1'b0; a_wr[2] = 1'b1; a_addr[2] = 32'h20; a_wdata[2] = 32'h55;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("mid_busy_pce", {31'b0, o_pce[2]}, 32'd0);
    a_rstn[2] = 1'b0;
    #1;
    chk("mid_rst_pce", {31'b0, o_pce[2]}, 32'd1);
    chk("mid_rst_dout", o_dout[2], 32'h0);
    chk("mid_rst_err", {31'b0, o_err[2]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    a_wr[2] = 1'b0;
    a_rstn[2] = 1'b1;
    exp_d[2] = '0; exp_e[2] = 1'b0;
    idle(2, 1);
    access(2, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    chk("mid_rst_nowrite", o_dout[2], mm[2][8]);
    chk("mid_rst_model", {24'b0, (mm[2][8] == 32'h55) ? 8'h1 : 8'h0}, 32'h0);

    // Randomized traffic with input scrambling during BUSY
    for (int n = 0; n < 90; n++) begin
      k   = int'($urandom_range(0, 2));
      sel = int'($urandom_range(0, 19));
      if (sel < 14)      addr = 32'($urandom_range(0, 15)) << 2;
      else if (sel < 17) addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else               addr = 32'h400 | ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 255)) << 2);
      sel = int'($urandom_range(0, 19));
      rd  = (sel < 9) || (sel >= 18);
      wr  = (sel >= 9);
      access(k, rd, wr, addr, $urandom, 1'b1);
      if ($urandom_range(0, 1) == 1) idle(k, int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
